// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller feeding the CP0 hardware
// interrupt input. Latches up to N_SRC requests (edge or level), applies a
// mask and a nested-priority threshold, and raises a registered IRQ_O for the
// highest-priority eligible source. The CPU claims and retires interrupts
// through a word-addressed register window.
//
// Ports:
//   CLK_I   system clock, rising-edge active
//   RST_I   asynchronous active-high reset
//   ADD_I   word address [4:2] within the controller window
//   WE_I    write enable
//   DAT_I   write data
//   DAT_O   read data, combinational from ADD_I and register state
//   IRQ_IN  source request lines, synchronous to CLK_I
//   IRQ_O   registered interrupt request to CP0
module irq_controller #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [4:2]       ADD_I,
  input  logic             WE_I,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  input  logic [N_SRC-1:0] IRQ_IN,
  output logic             IRQ_O
);

  localparam int unsigned ID_W = 3;

  localparam logic [2:0] A_MASK   = 3'd0;
  localparam logic [2:0] A_MODE   = 3'd1;
  localparam logic [2:0] A_PEND   = 3'd2;
  localparam logic [2:0] A_ACTIVE = 3'd3;
  localparam logic [2:0] A_EOI    = 3'd4;
  localparam logic [2:0] A_INSERV = 3'd5;

  localparam logic [31:0] RSVD_RD = 32'h8000_0000;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } state_e;

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] inserv_q, inserv_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  state_e           state_q, state_d;
  logic             irq_o_q, irq_o_d;

  logic             wr_mask, wr_mode, wr_pend, wr_claim, wr_eoi;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ins_oh;
  logic [N_SRC-1:0] above;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] elig_oh;
  logic             valid;
  logic [ID_W-1:0]  active_id;
  logic             id_found;
  logic             claim_fire;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] w1c;

  // Upper write-data bits have no storage behind them.
  logic unused_dat;
  assign unused_dat = ^DAT_I[31:N_SRC];

  // Bus write decode.
  always_comb begin
    wr_mask  = WE_I && (ADD_I == A_MASK);
    wr_mode  = WE_I && (ADD_I == A_MODE);
    wr_pend  = WE_I && (ADD_I == A_PEND);
    wr_claim = WE_I && (ADD_I == A_ACTIVE);
    wr_eoi   = WE_I && (ADD_I == A_EOI);
  end

  // Priority threshold, eligibility and ACTIVE id selection.
  always_comb begin
    ins_oh    = inserv_q & (~inserv_q + N_SRC'(1));
    // One-hot minus one gives the bits below h; with nothing in service the
    // subtraction wraps to all ones so every source is above threshold.
    above     = ins_oh - N_SRC'(1);
    eligible  = pend_q & mask_q & above;
    valid     = |eligible;
    elig_oh   = eligible & (~eligible + N_SRC'(1));
    active_id = '0;
    id_found  = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !id_found) begin
        active_id = ID_W'(i);
        id_found  = 1'b1;
      end
    end
  end

  // Register next-state: mask/mode, pending, in-service, edge detect.
  always_comb begin
    rise       = IRQ_IN & ~irq_q;
    irq_d      = IRQ_IN;
    claim_fire = wr_claim && valid;
    claim_clr  = claim_fire ? elig_oh : '0;
    w1c        = wr_pend ? DAT_I[N_SRC-1:0] : '0;

    mask_d = wr_mask ? DAT_I[N_SRC-1:0] : mask_q;
    mode_d = wr_mode ? DAT_I[N_SRC-1:0] : mode_q;

    // Edge bits: a new rise wins over W1C/CLAIM. Level bits track the line.
    pend_d = (mode_q & (rise | (pend_q & ~w1c & ~claim_clr)))
           | (~mode_q & IRQ_IN);

    inserv_d = inserv_q;
    if (claim_fire) begin
      inserv_d = inserv_q | elig_oh;
    end else if (wr_eoi) begin
      inserv_d = inserv_q & ~ins_oh;
    end
  end

  // Request FSM next-state and output.
  always_comb begin
    state_d = state_q;
    irq_o_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A claim of a not-yet-asserted source retires it immediately.
        if (valid && !claim_fire) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!valid || claim_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    irq_o_d = (state_d == ST_ASSERT);
  end

  // State registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      inserv_q <= '0;
      irq_q    <= '0;
      state_q  <= ST_IDLE;
      irq_o_q  <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      inserv_q <= inserv_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
      irq_o_q  <= irq_o_d;
    end
  end

  assign IRQ_O = irq_o_q;

  // Read mux.
  always_comb begin
    DAT_O = RSVD_RD;
    case (ADD_I)
      A_MASK:   DAT_O = 32'(mask_q);
      A_MODE:   DAT_O = 32'(mode_q);
      A_PEND:   DAT_O = 32'(pend_q);
      A_ACTIVE: DAT_O = {valid, 28'b0, active_id};
      A_EOI:    DAT_O = 32'(inserv_q);
      A_INSERV: DAT_O = 32'(inserv_q);
      default:  DAT_O = RSVD_RD;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vector table for irq_controller plus a few
// hand-written multi-cycle sequences (claim/rise race, async reset).
module tb_irq_controller;

  localparam logic [2:0] A_MASK = 3'd0;
  localparam logic [2:0] A_MODE = 3'd1;
  localparam logic [2:0] A_PEND = 3'd2;
  localparam logic [2:0] A_ACT  = 3'd3;
  localparam logic [2:0] A_EOI  = 3'd4;
  localparam logic [2:0] A_INS  = 3'd5;
  localparam logic [2:0] A_R6   = 3'd6;
  localparam logic [2:0] A_R7   = 3'd7;

  logic        clk;
  logic        rst;
  logic [2:0]  add;
  logic        we;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [5:0]  irq_in;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [5:0]  irq;
    logic [2:0]  ra;
    logic [31:0] want_dat;
    logic        want_irq;
  } vec_t;

  vec_t tbl[$];

  irq_controller #(.N_SRC(6)) dut (
    .CLK_I  (clk),
    .RST_I  (rst),
    .ADD_I  (add),
    .WE_I   (we),
    .DAT_I  (dat_i),
    .DAT_O  (dat_o),
    .IRQ_IN (irq_in),
    .IRQ_O  (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // One bus cycle: drive at negedge, clock, then switch to a read address.
  task automatic apply(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [5:0] irq, input logic [2:0] ra);
    @(negedge clk);
    we = w; add = wa; dat_i = wd; irq_in = irq;
    @(posedge clk);
    #1;
    we = 1'b0; add = ra;
    #1;
  endtask

  task automatic add_v(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [5:0] irq, input logic [2:0] ra,
                       input logic [31:0] want_dat, input logic want_irq);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.irq = irq; v.ra = ra;
    v.want_dat = want_dat; v.want_irq = want_irq;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; add = '0; dat_i = '0; irq_in = '0;

    // Reset state reads
    add_v(0, 0, 0, 6'h00, A_MASK, 32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_MODE, 32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_ACT,  32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_EOI,  32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_INS,  32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_R6,   32'h8000_0000, 0);
    add_v(0, 0, 0, 6'h00, A_R7,   32'h8000_0000, 0);
    // Single edge source
    add_v(1, A_MODE, 32'h01, 6'h00, A_MODE, 32'h01, 0);
    add_v(1, A_MASK, 32'h01, 6'h00, A_MASK, 32'h01, 0);
    add_v(0, 0, 0, 6'h01, A_PEND, 32'h01, 0);
    add_v(0, 0, 0, 6'h00, A_ACT,  32'h8000_0000, 1);
    add_v(1, A_ACT, 0, 6'h00, A_INS, 32'h01, 0);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 0);
    add_v(1, A_EOI, 0, 6'h00, A_EOI, 32'h0, 0);
    // Priority and nesting
    add_v(1, A_MODE, 32'h3F, 6'h00, A_MODE, 32'h3F, 0);
    add_v(1, A_MASK, 32'h3F, 6'h00, A_MASK, 32'h3F, 0);
    add_v(0, 0, 0, 6'h08, A_PEND, 32'h08, 0);
    add_v(0, 0, 0, 6'h08, A_ACT,  32'h8000_0003, 1);
    add_v(1, A_ACT, 0, 6'h08, A_INS, 32'h08, 0);
    add_v(0, 0, 0, 6'h28, A_PEND, 32'h20, 0);
    add_v(0, 0, 0, 6'h28, A_ACT,  32'h0, 0);
    add_v(0, 0, 0, 6'h2A, A_PEND, 32'h22, 0);
    add_v(0, 0, 0, 6'h2A, A_ACT,  32'h8000_0001, 1);
    add_v(1, A_ACT, 0, 6'h2A, A_INS, 32'h0A, 0);
    add_v(1, A_EOI, 0, 6'h2A, A_INS, 32'h08, 0);
    add_v(0, 0, 0, 6'h2A, A_ACT,  32'h0, 0);
    add_v(1, A_EOI, 0, 6'h2A, A_INS, 32'h0, 0);
    add_v(0, 0, 0, 6'h2A, A_ACT,  32'h8000_0005, 1);
    add_v(1, A_PEND, 32'h20, 6'h2A, A_PEND, 32'h0, 1);
    add_v(0, 0, 0, 6'h00, A_R7,   32'h8000_0000, 0);
    // Level source hold-off
    add_v(1, A_MODE, 32'h00, 6'h00, A_MODE, 32'h0, 0);
    add_v(1, A_MASK, 32'h04, 6'h00, A_MASK, 32'h04, 0);
    add_v(0, 0, 0, 6'h04, A_PEND, 32'h04, 0);
    add_v(0, 0, 0, 6'h04, A_ACT,  32'h8000_0002, 1);
    add_v(1, A_ACT, 0, 6'h04, A_INS, 32'h04, 0);
    add_v(0, 0, 0, 6'h04, A_PEND, 32'h04, 0);
    add_v(0, 0, 0, 6'h04, A_ACT,  32'h0, 0);
    add_v(1, A_EOI, 0, 6'h04, A_INS, 32'h0, 0);
    add_v(0, 0, 0, 6'h04, A_ACT,  32'h8000_0002, 1);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 1);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 0);
    // Masking, invalid claim, old-mask rule, W1C races
    add_v(1, A_MODE, 32'h3F, 6'h00, A_MODE, 32'h3F, 0);
    add_v(1, A_MASK, 32'h00, 6'h00, A_MASK, 32'h0, 0);
    add_v(0, 0, 0, 6'h01, A_PEND, 32'h01, 0);
    add_v(0, 0, 0, 6'h00, A_ACT,  32'h0, 0);
    add_v(1, A_ACT, 0, 6'h00, A_INS, 32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h01, 0);
    add_v(1, A_MASK, 32'h01, 6'h00, A_MASK, 32'h01, 0);
    add_v(0, 0, 0, 6'h00, A_ACT,  32'h8000_0000, 1);
    add_v(1, A_PEND, 32'h01, 6'h00, A_PEND, 32'h0, 1);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 0);
    add_v(0, 0, 0, 6'h10, A_PEND, 32'h10, 0);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h10, 0);
    add_v(1, A_PEND, 32'h10, 6'h10, A_PEND, 32'h10, 0);
    add_v(1, A_PEND, 32'h10, 6'h10, A_PEND, 32'h0, 0);
    add_v(0, 0, 0, 6'h00, A_PEND, 32'h0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].irq, tbl[i].ra);
      chk($sformatf("vec%0d dat", i), dat_o, tbl[i].want_dat);
      chk($sformatf("vec%0d irq_o", i), 32'(irq_o), 32'(tbl[i].want_irq));
    end

    // CLAIM racing a new rise on the same source: pending survives, and the
    // in-service threshold blocks it until EOI.
    apply(0, 0, 0, 6'h01, A_PEND);
    chk("race pend", dat_o, 32'h01);
    apply(0, 0, 0, 6'h00, A_ACT);
    chk("race act", dat_o, 32'h8000_0000);
    chk("race irq before claim", 32'(irq_o), 32'h1);
    apply(1, A_ACT, 0, 6'h01, A_PEND);
    chk("race pend after claim", dat_o, 32'h01);
    chk("race irq after claim", 32'(irq_o), 32'h0);
    apply(0, 0, 0, 6'h00, A_INS);
    chk("race inserv", dat_o, 32'h01);
    chk("race irq held off", 32'(irq_o), 32'h0);
    apply(1, A_EOI, 0, 6'h00, A_INS);
    chk("race inserv after eoi", dat_o, 32'h0);
    chk("race irq at eoi", 32'(irq_o), 32'h0);
    apply(0, 0, 0, 6'h00, A_ACT);
    chk("race reassert", 32'(irq_o), 32'h1);

    // Asynchronous reset mid-cycle while IRQ_O is high.
    #1 rst = 1'b1;
    #1 chk("async rst irq_o", 32'(irq_o), 32'h0);
    add = A_MASK; #1 chk("async rst mask", dat_o, 32'h0);
    add = A_PEND; #1 chk("async rst pend", dat_o, 32'h0);
    add = A_INS;  #1 chk("async rst inserv", dat_o, 32'h0);
    add = A_R6;   #1 chk("async rst addr6", dat_o, 32'h8000_0000);
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 6'h00, A_ACT);
    chk("post rst act", dat_o, 32'h0);
    chk("post rst irq_o", 32'(irq_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritised interrupt controller between the bus-mapped peripherals (timers and other IRQ sources) and the CPU's coprocessor-0 hardware interrupt input. It latches up to N_SRC source requests, applies per-source masking and edge/level mode, and raises a single registered IRQ_O for the highest-priority eligible source. The CPU claims and retires interrupts through a small register window on the same word-addressed peripheral bus the timers use. Nested interrupts are supported: only strictly higher-priority sources preempt one in service.

## Interface
- N_SRC, 6, number of interrupt sources (1..8); source 0 is highest priority.
- CLK_I  in  1  system clock; all state updates on rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- ADD_I  in  3 ([4:2])  word address within the controller window.
- WE_I  in  1  write enable; a write takes effect on the rising edge where WE_I=1.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data; combinational from ADD_I and register state.
- IRQ_IN  in  N_SRC  source request lines, synchronous to CLK_I (e.g. timer IRQ outputs).
- IRQ_O  out  1  registered interrupt request to CP0.

## Operation
- Register map (ADD_I):
  - 0: MASK, RW, bits [N_SRC-1:0]; 1 = enabled. Other bits read 0.
  - 1: MODE, RW, bits [N_SRC-1:0]; 1 = edge-triggered, 0 = level.
  - 2: PEND, RO; writes clear edge-mode bits where DAT_I bit = 1 (W1C). Level bits ignore writes.
  - 3: ACTIVE on read, {valid in bit 31, 28'b0, id in [2:0]}. Writing any data = CLAIM.
  - 4: EOI on write (data ignored). Reads return INSERV.
  - 5: INSERV, RO, bits [N_SRC-1:0].
  - 6, 7: read 32'h80000000; writes ignored.
- Edge detection: irq_q registers IRQ_IN every cycle. rise = IRQ_IN & ~irq_q.
- Edge-mode PEND[i] is set on the edge where rise[i]=1. It is cleared by W1C or CLAIM of i.
- Level-mode PEND[i] is loaded with IRQ_IN[i] every edge.
- Priority threshold: let h be the lowest-indexed set INSERV bit. Only sources with index < h are above the threshold; if INSERV = 0, all sources are above.
- Eligibility: eligible = PEND & MASK & above-threshold.
- ACTIVE selection: the ACTIVE id is the lowest set bit of eligible, and valid = |eligible.
- State machine:
  - IDLE: IRQ_O = 0. Go to ASSERT when |eligible.
  - ASSERT: IRQ_O = 1.
    - If eligible becomes 0 (mask, W1C or level drop), return to IDLE.
    - On CLAIM with valid: set INSERV[id]; clear edge-mode PEND[id]; go to IDLE.
    - The next ASSERT is reached only via a higher-priority source.
- CLAIM with valid = 0 has no effect.
- EOI clears INSERV[h]. EOI with INSERV = 0 has no effect.
- Level source in service: it stays pending but is blocked by the threshold until EOI. After EOI it re-asserts if its line is still high.
- Simultaneous events:
  - A rise on i in the same cycle as W1C or CLAIM of i leaves PEND[i] = 1 (set wins).
  - CLAIM and EOI are separate addresses, so they never coincide.
  - A mask write in the same cycle as an event uses the old MASK for that cycle's eligibility.

## Timing
- Reset (asynchronous, immediate): MASK, MODE, PEND, INSERV and irq_q are all 0; state is IDLE; IRQ_O = 0.
  - Reset mid-service discards all pending and in-service state.
- Edge source: IRQ_IN[i] rises before edge t. PEND[i] = 1 after t. IRQ_O = 1 after edge t+1 (2-cycle latency).
- Level source: same 2-cycle latency from IRQ_IN to IRQ_O.
- CLAIM written at edge t: IRQ_O = 0 after t. A new higher-priority request can raise IRQ_O after t+1 at the earliest.
- EOI at edge t: threshold updates after t. A re-enabled source raises IRQ_O after t+1.
- DAT_O reflects register state after the last edge with no extra latency.

## Test plan
- Reset then idle:
  - Stimulus: RST_I pulsed mid-cycle while IRQ_O = 1.
  - Required: IRQ_O drops without a clock edge; MASK/PEND/INSERV read 0; address 6 reads 32'h80000000.
- Single edge source:
  - Stimulus: MODE = 6'h01, MASK = 6'h01, then pulse IRQ_IN[0] for 1 cycle.
  - Required: PEND = 1 one edge later; IRQ_O = 1 two edges later; ACTIVE = 32'h80000000.
  - Then CLAIM. Required: IRQ_O = 0, INSERV = 1, PEND = 0. EOI → INSERV = 0.
- Priority and nesting:
  - Stimulus: all sources enabled as edge. Raise source 3; claim it (INSERV = 6'h08). Then raise source 5, then source 1.
  - Required: source 5 never asserts IRQ_O; source 1 asserts it with ACTIVE id = 1.
  - Claim 1, EOI. Required: INSERV = 6'h08. Second EOI: INSERV = 0, then source 5 asserts.
- Level source hold-off:
  - Stimulus: MODE = 0, MASK = 6'h04, IRQ_IN[2] held high; claim it.
  - Required: IRQ_O stays 0 while in service; after EOI, IRQ_O = 1 again two edges later. Drop IRQ_IN[2] → IRQ_O = 0.
- Masking and W1C races:
  - Stimulus: source pending with MASK = 0. Required: IRQ_O stays 0.
  - Stimulus: W1C on PEND[4] in the same cycle as a new rise on 4. Required: PEND[4] stays 1.
  - Stimulus: CLAIM while valid = 0. Required: INSERV unchanged.
